// File: rtl/stp16_receiver_pkg.sv
// Shared STP16 link constants, used by both the transmitter and the receiver.
package stp16_receiver_pkg;

  localparam int STP16_DEFAULT_WIDTH  = 64;
  localparam int STP16_SYNC_STAGES    = 2;
  localparam int STP16_MIN_PHASE_CLKS = 2;

endpackage

// File: rtl/stp16_receiver_sync_edge_detect.sv
// Pin synchronizer plus history flop; rise pulses for one clk when the synced level goes high.
// Latency: STAGES clk cycles from pin to level/rise. There is no backpressure.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/stp16_receiver.sv
// STP16 serial receive: oversampled shift/latch into a one-entry valid/ready slot.
// Latency: pin LE rise to o_valid is sync_stages+1 clk. When the slot is full, new frames are dropped and flagged.
module stp16_receiver
  import stp16_receiver_pkg::*;
#(
  parameter int width       = STP16_DEFAULT_WIDTH,
  parameter int sync_stages = STP16_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stp16_clk,
  input  logic             stp16_sdi,
  input  logic             stp16_le,
  input  logic             stp16_noe,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_data,
  output logic             o_enable,
  output logic             o_frame_error,
  output logic             o_overrun,
  input  logic             i_clear_flags
);

  localparam int CW = $clog2(width + 2);

  logic clk_lvl, clk_rise, sdi_lvl, sdi_rise, le_lvl, le_rise, noe_lvl, noe_rise;
  logic unused_pins;

  sync_edge_detect #(.STAGES(sync_stages)) u_clk (
    .clk(clk), .reset(reset), .pin_i(stp16_clk), .level_o(clk_lvl), .rise_o(clk_rise));
  sync_edge_detect #(.STAGES(sync_stages)) u_sdi (
    .clk(clk), .reset(reset), .pin_i(stp16_sdi), .level_o(sdi_lvl), .rise_o(sdi_rise));
  sync_edge_detect #(.STAGES(sync_stages)) u_le (
    .clk(clk), .reset(reset), .pin_i(stp16_le), .level_o(le_lvl), .rise_o(le_rise));
  sync_edge_detect #(.STAGES(sync_stages)) u_noe (
    .clk(clk), .reset(reset), .pin_i(stp16_noe), .level_o(noe_lvl), .rise_o(noe_rise));

  assign unused_pins = ^{clk_lvl, sdi_rise, le_lvl, noe_rise};

  logic [width-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             en_q;

  always_comb begin
    shift_d = shift_q;
    cnt_inc = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = i_clear_flags ? 1'b0 : err_q;
    ovr_d   = i_clear_flags ? 1'b0 : ovr_q;

    if (clk_rise) begin
      shift_d = {shift_q[width-2:0], sdi_lvl};
      if (cnt_q != CW'(width + 1)) cnt_inc = cnt_q + 1'b1;
    end
    cnt_d = cnt_inc;

    if (valid_q && o_ready) valid_d = 1'b0;

    // A same-cycle clk edge is already folded into shift_d/cnt_inc, so the latch sees that bit.
    if (le_rise) begin
      cnt_d = '0;
      if (cnt_inc != CW'(width)) err_d = 1'b1;
      if (!valid_q || o_ready) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      en_q    <= ~noe_lvl;
    end
  end

  assign o_valid       = valid_q;
  assign o_data        = data_q;
  assign o_enable      = en_q;
  assign o_frame_error = err_q;
  assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_stp16_receiver.sv
// Directed bench for stp16_receiver: round trip, short/long frames, backpressure, back-to-back, reset.
module tb_stp16_receiver;
  import stp16_receiver_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stp16_clk, stp16_sdi, stp16_le, stp16_noe;
  logic        o_valid, o_ready;
  logic [63:0] o_data;
  logic        o_enable, o_frame_error, o_overrun, i_clear_flags;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stp16_receiver dut (
    .clk(clk), .reset(reset),
    .stp16_clk(stp16_clk), .stp16_sdi(stp16_sdi), .stp16_le(stp16_le), .stp16_noe(stp16_noe),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_enable(o_enable),
    .o_frame_error(o_frame_error), .o_overrun(o_overrun), .i_clear_flags(i_clear_flags));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit per 8 clk: low phase with SDI set up, high phase, then back low.
  task automatic send_bit(input logic b);
    stp16_sdi = b;
    stp16_clk = 1'b0;
    repeat (STP16_MIN_PHASE_CLKS) tick();
    stp16_clk = 1'b1;
    repeat (2 * STP16_MIN_PHASE_CLKS) tick();
    stp16_clk = 1'b0;
    repeat (STP16_MIN_PHASE_CLKS) tick();
  endtask

  task automatic send_bits(input logic [127:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pulse_le();
    stp16_le = 1'b1;
    repeat (4) tick();
    stp16_le = 1'b0;
    repeat (4) tick();
  endtask

  task automatic clear_flags();
    i_clear_flags = 1'b1;
    tick();
    i_clear_flags = 1'b0;
  endtask

  task automatic accept();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stp16_clk = 1'b0; stp16_sdi = 1'b0; stp16_le = 1'b0; stp16_noe = 1'b1;
    o_ready = 1'b0; i_clear_flags = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_enable", 64'(o_enable), 64'd0);
    chk("rst_ferr", 64'(o_frame_error), 64'd0);
    chk("rst_ovr", 64'(o_overrun), 64'd0);
    reset = 1'b0;
    repeat (4) tick();

    // Round trip with latency check
    send_bits({64'd0, 64'hDEAD_BEEF_0123_4567}, 64);
    stp16_le = 1'b1;
    tick(); tick();
    chk("lat_pre_valid", 64'(o_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(o_valid), 64'd1);
    chk("rt_data", o_data, 64'hDEAD_BEEF_0123_4567);
    chk("rt_ferr", 64'(o_frame_error), 64'd0);
    chk("rt_ovr", 64'(o_overrun), 64'd0);
    repeat (3) tick();
    stp16_le = 1'b0;
    repeat (4) tick();
    chk("rt_hold_valid", 64'(o_valid), 64'd1);
    accept();
    chk("rt_acc_valid", 64'(o_valid), 64'd0);

    // Output enable follows ~noe with LE latency
    stp16_noe = 1'b0;
    tick(); tick();
    chk("en_pre", 64'(o_enable), 64'd0);
    tick();
    chk("en", 64'(o_enable), 64'd1);

    // Short frame: 63 bits; top bit is the leftover LSB of the previous frame
    send_bits({64'd0, 64'h1111_2222_3333_4444}, 63);
    pulse_le();
    chk("short_valid", 64'(o_valid), 64'd1);
    chk("short_data", o_data, 64'h9111_2222_3333_4444);
    chk("short_ferr", 64'(o_frame_error), 64'd1);
    clear_flags();
    chk("short_clr", 64'(o_frame_error), 64'd0);
    accept();

    // Long frame: 70 bits, keeps last 64
    send_bits({58'd0, 6'b101010, 64'hCAFE_F00D_1234_5678}, 70);
    pulse_le();
    chk("long_data", o_data, 64'hCAFE_F00D_1234_5678);
    chk("long_ferr", 64'(o_frame_error), 64'd1);
    clear_flags();
    accept();

    // Backpressure: B is dropped, A persists
    send_bits({64'd0, 64'hAAAA_5555_0F0F_F0F0}, 64);
    pulse_le();
    send_bits({64'd0, 64'h1234_5678_9ABC_DEF0}, 64);
    pulse_le();
    chk("bp_valid", 64'(o_valid), 64'd1);
    chk("bp_data", o_data, 64'hAAAA_5555_0F0F_F0F0);
    chk("bp_ovr", 64'(o_overrun), 64'd1);
    chk("bp_ferr", 64'(o_frame_error), 64'd0);
    accept();
    chk("bp_acc_valid", 64'(o_valid), 64'd0);
    repeat (3) tick();
    chk("bp_once", 64'(o_valid), 64'd0);
    clear_flags();
    chk("bp_ovr_clr", 64'(o_overrun), 64'd0);

    // Back-to-back: B's LE edge lands in the acceptance cycle of A
    send_bits({64'd0, 64'h5A5A_A5A5_3C3C_C3C3}, 64);
    pulse_le();
    chk("b2b_a_data", o_data, 64'h5A5A_A5A5_3C3C_C3C3);
    send_bits({64'd0, 64'h0BAD_F00D_7777_8888}, 64);
    stp16_le = 1'b1;
    tick(); tick();
    o_ready = 1'b1;
    tick();
    chk("b2b_valid", 64'(o_valid), 64'd1);
    chk("b2b_data", o_data, 64'h0BAD_F00D_7777_8888);
    chk("b2b_ovr", 64'(o_overrun), 64'd0);
    tick();
    chk("b2b_acc_valid", 64'(o_valid), 64'd0);
    o_ready = 1'b0;
    repeat (2) tick();
    stp16_le = 1'b0;
    repeat (4) tick();

    // Reset mid-frame
    send_bits({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 30);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_data", o_data, 64'd0);
    chk("mid_rst_enable", 64'(o_enable), 64'd0);
    chk("mid_rst_ferr", 64'(o_frame_error), 64'd0);
    chk("mid_rst_ovr", 64'(o_overrun), 64'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    send_bits({64'd0, 64'h0F1E_2D3C_4B5A_6978}, 64);
    pulse_le();
    chk("c_valid", 64'(o_valid), 64'd1);
    chk("c_data", o_data, 64'h0F1E_2D3C_4B5A_6978);
    chk("c_ferr", 64'(o_frame_error), 64'd0);
    chk("c_ovr", 64'(o_overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
